// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter: round-robin sharing of the i2c_single_reg local write port with an
// enforced hold time between updates, plus detection of bytes written by the I2C master.
module i2c_reg_arbiter #(
   parameter int PORTS       = 4,
   parameter int HOLD_CYCLES = 16,
   localparam int IW         = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PORTS-1:0]   req_valid,
   input  logic [PORTS*8-1:0] req_data,
   output logic [PORTS-1:0]   req_ready,
   output logic [IW-1:0]      grant_idx,
   output logic [7:0]         reg_data_in,
   output logic               reg_data_latch,
   input  logic [7:0]         reg_data_out,
   output logic               host_wr_valid,
   output logic [7:0]         host_wr_data,
   input  logic               host_wr_ready,
   output logic               host_overrun,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LATCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES);

   state_t        state_r;
   logic [IW-1:0] last_r;
   logic [IW-1:0] winner_s;
   logic [IW-1:0] cand_s;
   logic          any_s;
   logic [7:0]    win_data_s;
   logic [15:0]   cnt_r;
   logic          expect_r;
   logic [7:0]    shadow_r;
   logic          host_wr_s;

   assign any_s      = |req_valid;
   assign win_data_s = req_data[{winner_s, 3'b000} +: 8];
   assign busy       = (state_r != S_IDLE);
   assign host_wr_s  = (reg_data_out != shadow_r) && !expect_r;

   // Round-robin search: walk downward so the candidate nearest last grant + 1 wins
   always_comb begin
      winner_s = '0;
      cand_s   = '0;
      for (int k = PORTS; k >= 1; k--) begin
         cand_s   = IW'((int'(last_r) + k) % PORTS);
         winner_s = req_valid[cand_s] ? cand_s : winner_s;
      end
   end

   // One-hot accept, only while idle
   always_comb begin
      req_ready = '0;
      if (state_r == S_IDLE && any_s) begin
         req_ready[winner_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Grant / latch / hold sequencer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= S_IDLE;
         last_r         <= IW'(PORTS - 1);
         cnt_r          <= 16'd0;
         grant_idx      <= '0;
         reg_data_in    <= 8'd0;
         reg_data_latch <= 1'b0;
         expect_r       <= 1'b0;
      end else begin
         reg_data_latch <= 1'b0;
         expect_r       <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (any_s) begin
                  grant_idx      <= winner_s;
                  last_r         <= winner_s;
                  reg_data_in    <= win_data_s;
                  reg_data_latch <= 1'b1;
                  state_r        <= S_LATCH;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_LATCH: begin
               // Slave output changes next cycle; mask that one comparison
               expect_r <= 1'b1;
               cnt_r    <= HOLD_LOAD;
               state_r  <= (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
               cnt_r <= cnt_r - 16'd1;
               if (cnt_r <= 16'd1) begin
                  state_r <= S_IDLE;
               end else begin
                  state_r <= S_HOLD;
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // Shadow of the slave output and single-entry host-write event buffer
   always_ff @(posedge clk) begin
      shadow_r <= reg_data_out;
      if (rst) begin
         host_wr_valid <= 1'b0;
         host_wr_data  <= 8'd0;
         host_overrun  <= 1'b0;
      end else begin
         host_overrun <= 1'b0;
         if (host_wr_s) begin
            host_wr_data  <= reg_data_out;
            host_wr_valid <= 1'b1;
            host_overrun  <= host_wr_valid && !host_wr_ready;
         end else if (host_wr_valid && host_wr_ready) begin
            host_wr_valid <= 1'b0;
         end else begin
            host_wr_valid <= host_wr_valid;
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Directed bench for i2c_reg_arbiter: one instance with HOLD_CYCLES=2 driving a slave
// model that also accepts host writes, and one with HOLD_CYCLES=0 for back-to-back traffic.
module tb_i2c_reg_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0]  req_valid, req_ready;
   logic [31:0] req_data;
   logic [1:0]  grant_idx;
   logic [7:0]  reg_data_in, reg_data_out, host_wr_data;
   logic        reg_data_latch, host_wr_valid, host_wr_ready, host_overrun, busy;

   logic [3:0]  req_valid_z, req_ready_z;
   logic [31:0] req_data_z;
   logic [1:0]  grant_idx_z;
   logic [7:0]  reg_data_in_z, reg_data_out_z, host_wr_data_z;
   logic        reg_data_latch_z, host_wr_valid_z, host_overrun_z, busy_z;

   logic [7:0]  slave   = 8'h00;
   logic [7:0]  slave_z = 8'h00;
   logic        host_we;
   logic [7:0]  host_val;
   int          cyc = 0;

   assign reg_data_out   = slave;
   assign reg_data_out_z = slave_z;

   // Slave register models: local latch wins over a simultaneous host write
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reg_data_latch) slave <= reg_data_in;
      else if (host_we) slave <= host_val;
      if (reg_data_latch_z) slave_z <= reg_data_in_z;
   end

   i2c_reg_arbiter #(.PORTS(4), .HOLD_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .grant_idx(grant_idx), .reg_data_in(reg_data_in),
      .reg_data_latch(reg_data_latch), .reg_data_out(reg_data_out),
      .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data),
      .host_wr_ready(host_wr_ready), .host_overrun(host_overrun), .busy(busy)
   );

   i2c_reg_arbiter #(.PORTS(4), .HOLD_CYCLES(0)) dut_z (
      .clk(clk), .rst(rst), .req_valid(req_valid_z), .req_data(req_data_z),
      .req_ready(req_ready_z), .grant_idx(grant_idx_z), .reg_data_in(reg_data_in_z),
      .reg_data_latch(reg_data_latch_z), .reg_data_out(reg_data_out_z),
      .host_wr_valid(host_wr_valid_z), .host_wr_data(host_wr_data_z),
      .host_wr_ready(1'b1), .host_overrun(host_overrun_z), .busy(busy_z)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      @(negedge clk);
      while (busy && c < 40) begin
         @(negedge clk);
         c++;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  ready;
      logic [1:0]  idx;
      logic [7:0]  lat;
   } vec_t;

   vec_t       vt [9];
   logic [1:0] ord [5];
   logic [7:0] zseq [4];

   initial begin
      int n, k, m, ev, ovr, last_c;
      logic acc, prev_acc;

      vt[0] = '{4'b0100, 32'h00A50000, 4'b0100, 2'd2, 8'hA5};
      vt[1] = '{4'b1111, 32'h13121110, 4'b1000, 2'd3, 8'h13};
      vt[2] = '{4'b1111, 32'h13121110, 4'b0001, 2'd0, 8'h10};
      vt[3] = '{4'b1111, 32'h13121110, 4'b0010, 2'd1, 8'h11};
      vt[4] = '{4'b1111, 32'h13121110, 4'b0100, 2'd2, 8'h12};
      vt[5] = '{4'b0011, 32'h13121110, 4'b0001, 2'd0, 8'h10};
      vt[6] = '{4'b0011, 32'h13121110, 4'b0010, 2'd1, 8'h11};
      vt[7] = '{4'b1001, 32'h13121110, 4'b1000, 2'd3, 8'h13};
      vt[8] = '{4'b0000, 32'h13121110, 4'b0000, 2'd3, 8'h13};
      ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd3; ord[4] = 2'd0;
      zseq[0] = 8'h21; zseq[1] = 8'h22; zseq[2] = 8'h23; zseq[3] = 8'h24;

      rst = 1'b1; req_valid = 4'd0; req_data = 32'd0; host_we = 1'b0; host_val = 8'd0;
      host_wr_ready = 1'b1; req_valid_z = 4'd0; req_data_z = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_latch", {31'd0, reg_data_latch}, 32'd0);
      chk("rst_din", {24'd0, reg_data_in}, 32'd0);
      chk("rst_grant", {30'd0, grant_idx}, 32'd0);
      chk("rst_hwv", {31'd0, host_wr_valid}, 32'd0);
      chk("rst_hwd", {24'd0, host_wr_data}, 32'd0);
      chk("rst_ovr", {31'd0, host_overrun}, 32'd0);
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      @(posedge clk); #1; rst = 1'b0;

      // Table-driven arbitration with latch/hold timing per accept
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         req_valid = vt[i].valid; req_data = vt[i].data;
         @(negedge clk);
         chk("rr_ready", {28'd0, req_ready}, {28'd0, vt[i].ready});
         if (vt[i].ready != 4'd0) begin
            @(posedge clk); #1; req_valid = 4'd0;
            @(negedge clk);
            chk("lat_pulse", {31'd0, reg_data_latch}, 32'd1);
            chk("lat_data", {24'd0, reg_data_in}, {24'd0, vt[i].lat});
            chk("lat_grant", {30'd0, grant_idx}, {30'd0, vt[i].idx});
            chk("lat_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk("hold_nolatch", {31'd0, reg_data_latch}, 32'd0);
            chk("hold_busy1", {31'd0, busy}, 32'd1);
            chk("hold_ready0", {28'd0, req_ready}, 32'd0);
            @(negedge clk);
            chk("hold_busy2", {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk("idle_busy", {31'd0, busy}, 32'd0);
         end else begin
            chk("noreq_busy", {31'd0, busy}, 32'd0);
         end
         chk("no_host_evt", {31'd0, host_wr_valid}, 32'd0);
      end

      // All ports valid continuously: order 0,1,2,3,0 spaced 4 cycles
      @(posedge clk); #1; req_valid = 4'hF; req_data = 32'h13121110;
      n = 0; last_c = 0; prev_acc = 1'b0;
      for (int c = 0; c < 30 && n < 5; c++) begin
         @(negedge clk);
         if (prev_acc) chk("cont_grant", {30'd0, grant_idx}, {30'd0, ord[n-1]});
         prev_acc = (req_ready != 4'd0);
         if (prev_acc) begin
            chk("cont_order", {28'd0, req_ready}, 32'd1 << ord[n]);
            if (n > 0) chk("cont_spacing", cyc - last_c, 32'd4);
            last_c = cyc;
            n++;
         end
      end
      chk("cont_count", n, 32'd5);
      @(posedge clk); #1; req_valid = 4'd0;
      wait_idle();

      // Reset during HOLD with port 3 still requesting
      @(posedge clk); #1; req_valid = 4'b1000; req_data = 32'h77000000;
      @(negedge clk);
      chk("rsth_ready", {28'd0, req_ready}, 32'b1000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rsth_inhold", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rsth_busy", {31'd0, busy}, 32'd0);
      chk("rsth_din", {24'd0, reg_data_in}, 32'd0);
      chk("rsth_grant", {30'd0, grant_idx}, 32'd0);
      chk("rsth_latch", {31'd0, reg_data_latch}, 32'd0);
      @(posedge clk); #1; rst = 1'b0; req_valid = 4'b1001; req_data = 32'h77000055;
      @(negedge clk);
      chk("rsth_tie", {28'd0, req_ready}, 32'b0001);
      @(posedge clk); #1; req_valid = 4'd0;
      @(negedge clk);
      chk("rsth_lat", {31'd0, reg_data_latch}, 32'd1);
      chk("rsth_data", {24'd0, reg_data_in}, 32'h55);
      ev = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (host_wr_valid) ev++;
      end
      chk("rsth_noevt", ev, 32'd0);
      wait_idle();

      // Host write with consumer ready
      @(posedge clk); #1; host_val = 8'h3C; host_we = 1'b1;
      @(posedge clk); #1; host_we = 1'b0;
      @(negedge clk);
      chk("hw_not_yet", {31'd0, host_wr_valid}, 32'd0);
      @(negedge clk);
      chk("hw_valid", {31'd0, host_wr_valid}, 32'd1);
      chk("hw_data", {24'd0, host_wr_data}, 32'h3C);
      @(negedge clk);
      chk("hw_drop", {31'd0, host_wr_valid}, 32'd0);

      // Locally caused change to 0xA5 must not raise an event
      @(posedge clk); #1; req_valid = 4'b0100; req_data = 32'h00A50000;
      @(negedge clk);
      chk("loc_ready", {28'd0, req_ready}, 32'b0100);
      @(posedge clk); #1; req_valid = 4'd0;
      ev = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (host_wr_valid) ev++;
      end
      chk("loc_masked", ev, 32'd0);
      chk("loc_slave", {24'd0, reg_data_out}, 32'hA5);

      // Overrun: two host writes while the consumer stalls
      host_wr_ready = 1'b0;
      @(posedge clk); #1; host_val = 8'h01; host_we = 1'b1;
      @(posedge clk); #1; host_we = 1'b0;
      @(posedge clk); #1; host_val = 8'h02; host_we = 1'b1;
      @(negedge clk);
      chk("ovr_first", {23'd0, host_wr_valid, host_wr_data}, 32'h101);
      @(posedge clk); #1; host_we = 1'b0;
      ovr = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (host_overrun) ovr++;
      end
      chk("ovr_count", ovr, 32'd1);
      chk("ovr_keep", {23'd0, host_wr_valid, host_wr_data}, 32'h102);
      @(posedge clk); #1; host_wr_ready = 1'b1;
      @(negedge clk);
      chk("ovr_hs", {31'd0, host_wr_valid}, 32'd1);
      @(negedge clk);
      chk("ovr_clear", {31'd0, host_wr_valid}, 32'd0);

      // HOLD_CYCLES=0: back-to-back from port 1, accepts every 2 cycles
      @(posedge clk); #1; req_valid_z = 4'b0010; req_data_z = {16'd0, zseq[0], 8'd0};
      k = 0; m = 0; last_c = 0; ev = 0;
      for (int c = 0; c < 20 && m < 4; c++) begin
         @(negedge clk);
         if (host_wr_valid_z) ev++;
         if (reg_data_latch_z) begin
            chk("z_seq", {24'd0, reg_data_in_z}, {24'd0, zseq[m]});
            m++;
         end
         acc = req_ready_z[1];
         if (acc) begin
            chk("z_ready", {28'd0, req_ready_z}, 32'b0010);
            if (k > 0) chk("z_spacing", cyc - last_c, 32'd2);
            last_c = cyc;
            k++;
         end
         @(posedge clk); #1;
         if (acc) begin
            if (k < 4) req_data_z[15:8] = zseq[k];
            else req_valid_z = 4'd0;
         end
      end
      chk("z_accepts", k, 32'd4);
      chk("z_latches", m, 32'd4);
      chk("z_noevt", ev, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
